// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: direct-mapped table of 2-bit saturating
// counters read in IF, prediction carried into ID, trained by the ID comparator.
module branch_predictor #(
    parameter int unsigned INDEX_W    = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic        pred_takenF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branchD,
    input  logic        takenD,
    output logic        pred_takenD,
    output logic        mispredictD,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned DEPTH = 1 << INDEX_W;

    logic [1:0]         cnt_tbl [DEPTH];
    logic [INDEX_W-1:0] idxF;
    logic [INDEX_W-1:0] idxD;
    logic               upd;
    logic               unused_pc_bits;

    // Word-aligned fetch index; upper and byte-offset PC bits play no part.
    assign idxF           = pcF[INDEX_W+1:2];
    assign unused_pc_bits = ^{pcF[31:INDEX_W+2], pcF[1:0]};

    // Prediction is the counter MSB; mispredict resolves in the same ID cycle.
    assign pred_takenF = cnt_tbl[idxF][1];
    assign mispredictD = branchD & (pred_takenD != takenD);

    // A stalled branch trains only on the cycle it leaves ID.
    assign upd = branchD & ~stallD;

    // IF/ID prediction register; flush beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_takenD <= 1'b0;
            idxD        <= '0;
        end else if (flushD) begin
            pred_takenD <= 1'b0;
            idxD        <= '0;
        end else if (!stallD) begin
            pred_takenD <= pred_takenF;
            idxD        <= idxF;
        end
    end

    // Counter table: reinitialise on reset, otherwise saturating train on update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt_tbl[i] <= INIT_STATE;
            end
        end else if (upd) begin
            if (takenD) begin
                if (cnt_tbl[idxD] != 2'b11) begin
                    cnt_tbl[idxD] <= cnt_tbl[idxD] + 2'b01;
                end
            end else begin
                if (cnt_tbl[idxD] != 2'b00) begin
                    cnt_tbl[idxD] <= cnt_tbl[idxD] - 2'b01;
                end
            end
        end
    end

    // Resolved-branch and misprediction statistics, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= 32'd0;
            miss_cnt   <= 32'd0;
        end else if (upd) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredictD) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random
// traffic, all compared against a behavioural model of the counter table.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        pred_takenF;
    logic        stallD;
    logic        flushD;
    logic        branchD;
    logic        takenD;
    logic        pred_takenD;
    logic        mispredictD;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          tbl [64];
    bit          m_predD;
    int          m_idxD;
    logic [31:0] m_br;
    logic [31:0] m_miss;

    branch_predictor #(.INDEX_W(6), .INIT_STATE(2'b01)) dut (
        .clk         (clk),
        .rst         (rst),
        .pcF         (pcF),
        .pred_takenF (pred_takenF),
        .stallD      (stallD),
        .flushD      (flushD),
        .branchD     (branchD),
        .takenD      (takenD),
        .pred_takenD (pred_takenD),
        .mispredictD (mispredictD),
        .branch_cnt  (branch_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check combinational outputs, advance model, check registers.
    task automatic step(input logic [31:0] pc, input bit br, input bit tk,
                        input bit st, input bit fl, input bit r);
        int idx;
        bit exp_predF;
        bit exp_mis;
        pcF = pc; branchD = br; takenD = tk; stallD = st; flushD = fl; rst = r;
        #1;
        idx       = int'((pc >> 2) % 64);
        exp_predF = (tbl[idx] >= 2);
        exp_mis   = br && (m_predD != tk);
        if (!r) begin
            check("pred_takenF", 32'(pred_takenF), 32'(exp_predF));
            check("mispredictD", 32'(mispredictD), 32'(exp_mis));
        end
        @(posedge clk);
        if (r) begin
            foreach (tbl[i]) tbl[i] = 1;
            m_predD = 0; m_idxD = 0; m_br = 0; m_miss = 0;
        end else begin
            if (br && !st) begin
                m_br = m_br + 1;
                if (exp_mis) m_miss = m_miss + 1;
                if (tk) tbl[m_idxD] = (tbl[m_idxD] == 3) ? 3 : tbl[m_idxD] + 1;
                else    tbl[m_idxD] = (tbl[m_idxD] == 0) ? 0 : tbl[m_idxD] - 1;
            end
            if (fl) begin
                m_predD = 0; m_idxD = 0;
            end else if (!st) begin
                m_predD = exp_predF; m_idxD = idx;
            end
        end
        #1;
        check("pred_takenD", 32'(pred_takenD), 32'(m_predD));
        check("branch_cnt",  branch_cnt, m_br);
        check("miss_cnt",    miss_cnt,   m_miss);
    endtask

    localparam logic [31:0] PC0  = 32'h0040_0000;
    localparam logic [31:0] PCB  = 32'h0040_0010;
    localparam logic [31:0] PCA  = 32'h0040_0100;
    localparam logic [31:0] PCX  = 32'h0040_0020;

    initial begin
        foreach (tbl[i]) tbl[i] = 1;
        m_predD = 0; m_idxD = 0; m_br = 0; m_miss = 0;

        // Reset and initial prediction
        step(PC0, 0, 0, 0, 0, 1);
        step(PC0, 0, 0, 0, 0, 0);
        check("reset_predF", 32'(pred_takenF), 32'd0);

        // Train entry 4 taken twice: first mispredicts, second does not
        step(PCB, 0, 0, 0, 0, 0);
        step(PCX, 1, 1, 0, 0, 0);
        step(PCB, 0, 0, 0, 0, 0);
        step(PCX, 1, 1, 0, 0, 0);
        check("train_branch_cnt", branch_cnt, 32'd2);
        check("train_miss_cnt",   miss_cnt,   32'd1);
        step(PCB, 0, 0, 0, 0, 0);
        check("trained_predD", 32'(pred_takenD), 32'd1);

        // Saturation at 11, then four not-taken resolutions down to 00
        step(PCX, 1, 1, 0, 0, 0);
        step(PCB, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(PCB, 1, 0, 0, 0, 0);
        end
        step(PCB, 0, 0, 0, 0, 0);
        check("sat_low_predD", 32'(pred_takenD), 32'd0);

        // Stalled branch counted once, on release
        step(PCB, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(PCX, 1, 1, 1, 0, 0);
        end
        step(PCX, 1, 1, 0, 0, 0);

        // Flush with stall clears the ID prediction; bubble does nothing
        step(PCB, 0, 0, 0, 0, 0);
        step(PCB, 0, 0, 1, 1, 0);
        check("flush_predD", 32'(pred_takenD), 32'd0);
        step(PCB, 0, 1, 0, 0, 0);

        // Aliasing: 0x0040_0100 trains entry 0 shared with 0x0040_0000
        step(PCA, 0, 0, 0, 0, 0);
        step(PC0, 1, 1, 0, 0, 0);
        step(PC0, 0, 0, 0, 0, 0);
        check("alias_predD", 32'(pred_takenD), 32'd1);
        step(PCA, 1, 0, 0, 0, 0);
        step(PCA, 1, 0, 0, 0, 0);

        // Reset mid-stream drops the pending update
        step(PCB, 1, 1, 0, 0, 1);
        check("midreset_branch_cnt", branch_cnt, 32'd0);

        // Random traffic with aliasing PCs, stalls, flushes and rare resets
        for (int k = 0; k < 600; k++) begin
            step(PC0 + (32'($urandom_range(0, 127)) << 2),
                 bit'($urandom % 2), bit'($urandom % 2),
                 ($urandom % 5) == 0, ($urandom % 8) == 0, ($urandom % 150) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
